dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port 16-bit data memory of the RISC core.
- Requester 0 is the CPU load/store port. Requester 1 is the program/data loader or debug port.
- Round-robin arbitration with a burst limit, so a streaming requester cannot starve the other.
- Sits between system_cpu_master's data-memory interface and the data memory; memory read latency is one cycle.

Parameters:
- ADDR_W, 8, data memory word-address width.
- DATA_W, 16, data word width.
- MAX_BURST, 4, max consecutive grants to one owner while the other requester is waiting (legal range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  CPU access request.
- we0  in  1  CPU write enable (1 = store, 0 = load).
- addr0  in  ADDR_W  CPU word address.
- wdata0  in  DATA_W  CPU store data.
- gnt0  out  1  CPU access accepted this cycle.
- rvalid0  out  1  CPU load data valid on rdata.
- req1, we1, addr1, wdata1, gnt1, rvalid1: same as above, for the loader port.
- rdata  out  DATA_W  load data, shared by both requesters; qualified by rvalid0/rvalid1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe.

Behaviour:
- Registered state:
  - st: IDLE / OWN0 / OWN1.
  - last: last granted requester.
  - cnt: 4-bit consecutive-grant count.
  - rv0, rv1: read-valid flags.
- Reset (rst=1 at clk edge): st=IDLE, last=1 (CPU wins the first tie), cnt=0, rv0=rv1=0. Reset overrides any outstanding read; no rvalid follows a read issued in the reset cycle.
- Grant select (combinational, same cycle as req). At most one gnt high per cycle.
  - IDLE: req0&req1 selects the requester != last. A single req selects that requester. No req selects none.
  - OWNx (x = owner, y = other):
    - req_x & ~(req_y & cnt==MAX_BURST) selects x.
    - Otherwise req_y selects y.
    - Otherwise none.
  - gnt_i = req_i & (sel==i).
- Next state:
  - Grant to i: st=OWNi, last=i.
  - cnt=1 if i != previous owner or st was IDLE. Otherwise cnt=cnt+1, saturating at MAX_BURST.
  - No grant: st=IDLE, cnt=0.
- Memory drive (combinational):
  - mem_en = gnt0|gnt1.
  - mem_we, mem_addr and mem_wdata are muxed from the granted requester.
  - With no grant, all memory outputs are 0.
- Read return:
  - rv_i <= gnt_i & ~we_i.
  - rvalid_i = rv_i, exactly one cycle after the grant.
  - rdata = mem_rdata passthrough; rdata is don't-care when no rvalid is high.
- Writes complete in the grant cycle; there is no response.
- Requester rule: hold req/we/addr/wdata stable until gnt is seen. Deasserting req before gnt is legal (request withdrawn, nothing issued).
- Back-to-back: a requester may be granted every cycle. A read grant at cycle N and a new grant at N+1 overlap legally (pipelined).
- Burst limit boundary:
  - Applies only while the other requester is waiting.
  - A lone requester is granted indefinitely and cnt saturates at MAX_BURST.
  - If y waits at cnt==MAX_BURST, y gets the next cycle even though req_x is still high.
- Simultaneous first requests after reset: CPU wins. After that, ties alternate by last.

Test Plan:
- Reset with req0=req1=1, we=0: during rst, gnt0=gnt1=0 and mem_en=0. First cycle after reset: gnt0=1, mem_addr=addr0. Next cycle: rvalid0=1.
- CPU only, load addr0=0x10, mem returns 0xBEEF: gnt0 in cycle N, rvalid0=1 with rdata=0xBEEF in N+1, rvalid1=0 throughout.
- Loader stream of 10 writes, CPU idle: gnt1=1 for all 10 consecutive cycles, mem_we=1, and mem_wdata follows wdata1 each cycle.
- Both requesting continuously, MAX_BURST=4, CPU owning: grant pattern 0,0,0,0,1,1,1,1,0,... Neither requester waits more than 4 cycles.
- Read at cycle N, rst asserted at N+1: rvalid0=0 at N+1 and N+2. After reset, st=IDLE and the first tie goes to the CPU.
- Loader withdraws req1 before grant while the CPU bursts: no gnt1 and no mem access with addr1. CPU grants continue and cnt saturates at 4.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the
// single-port data memory. The arbiter uses the slave view; the requester/memory
// side uses the master view.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              rvalid0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              rvalid1;

    logic [DATA_W-1:0] rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        output gnt0, rvalid0, gnt1, rvalid1, rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
        input  gnt0, rvalid0, gnt1, rvalid1, rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter for the shared single-port data memory.
// Requester 0 is the CPU, requester 1 the loader/debug port. An owner keeps
// the memory while it requests, but yields after MAX_BURST consecutive grants
// if the other side is waiting. Reads return one cycle after the grant.
module dmem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} st_t;

    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    st_t        st, st_nx;
    logic       last, last_nx;
    logic [3:0] cnt, cnt_nx;
    logic       rv0, rv1;

    logic       g0, g1;
    logic       own, r_own, r_oth, take_own, take_oth, at_lim;

    // State register; reset also kills any read issued in the reset cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            st   <= IDLE;
            last <= 1'b1;
            cnt  <= 4'd0;
            rv0  <= 1'b0;
            rv1  <= 1'b0;
        end else begin
            st   <= st_nx;
            last <= last_nx;
            cnt  <= cnt_nx;
            rv0  <= g0 & ~bus.we0;
            rv1  <= g1 & ~bus.we1;
        end
    end

    // Grant select and next-state: tie-break on last in IDLE, burst limit while owning.
    always_comb begin
        g0       = 1'b0;
        g1       = 1'b0;
        take_own = 1'b0;
        take_oth = 1'b0;
        own      = (st == OWN1);
        r_own    = own ? bus.req1 : bus.req0;
        r_oth    = own ? bus.req0 : bus.req1;
        at_lim   = (cnt >= MAXB);
        st_nx    = IDLE;
        last_nx  = last;
        cnt_nx   = 4'd0;

        if (!rst) begin
            if (st == IDLE) begin
                if (bus.req0 && bus.req1) begin
                    g0 = last;
                    g1 = ~last;
                end else begin
                    g0 = bus.req0;
                    g1 = bus.req1;
                end
            end else begin
                if (r_own && !(r_oth && at_lim))
                    take_own = 1'b1;
                else if (r_oth)
                    take_oth = 1'b1;
                g0 = own ? take_oth : take_own;
                g1 = own ? take_own : take_oth;
            end
        end

        if (g0 || g1) begin
            st_nx   = g1 ? OWN1 : OWN0;
            last_nx = g1;
            if (st == IDLE || g1 != own)
                cnt_nx = 4'd1;
            else if (at_lim)
                cnt_nx = MAXB;
            else
                cnt_nx = cnt + 4'd1;
        end
    end

    assign bus.gnt0      = g0;
    assign bus.gnt1      = g1;
    assign bus.mem_en    = g0 | g1;
    assign bus.mem_we    = (g0 & bus.we0) | (g1 & bus.we1);
    assign bus.mem_addr  = g1 ? bus.addr1  : (g0 ? bus.addr0  : '0);
    assign bus.mem_wdata = g1 ? bus.wdata1 : (g0 ? bus.wdata0 : '0);

    // rvalid is masked while reset is asserted so a read in flight is dropped.
    assign bus.rvalid0   = rv0 & ~rst;
    assign bus.rvalid1   = rv1 & ~rst;
    assign bus.rdata     = bus.mem_rdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small one-cycle-latency memory model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(16), .MAX_BURST(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: write in the strobe cycle, read data one cycle later.
    logic [15:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int own_exp [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

        mem[8'h10] = 16'hBEEF;
        mem[8'h20] = 16'h1234;

        // Reset with both requesting reads
        rst = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10; bus.wdata0 = 16'h0;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20; bus.wdata1 = 16'h0;
        #2;
        chk("rst_gnt0", 32'(bus.gnt0), 0);
        chk("rst_gnt1", 32'(bus.gnt1), 0);
        chk("rst_men",  32'(bus.mem_en), 0);
        tick();
        tick();
        rst = 1'b0;

        // Both requesting continuously: bursts of 4, CPU first
        for (int i = 0; i < 9; i++) begin
            if (i != 0) tick();
            #2;
            chk($sformatf("bst_gnt0_%0d", i), 32'(bus.gnt0), (own_exp[i] == 0) ? 1 : 0);
            chk($sformatf("bst_gnt1_%0d", i), 32'(bus.gnt1), (own_exp[i] == 1) ? 1 : 0);
            chk($sformatf("bst_addr_%0d", i), 32'(bus.mem_addr), (own_exp[i] == 1) ? 32'h20 : 32'h10);
            if (i == 0) chk("bst_rv0_first", 32'(bus.rvalid0), 0);
            if (i == 1) begin
                chk("bst_rv0",   32'(bus.rvalid0), 1);
                chk("bst_rd0",   32'(bus.rdata), 32'hBEEF);
            end
            if (i == 5) begin
                chk("bst_rv1",   32'(bus.rvalid1), 1);
                chk("bst_rd1",   32'(bus.rdata), 32'h1234);
            end
        end
        tick();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        #2;
        chk("idle_men", 32'(bus.mem_en), 0);
        chk("idle_maddr", 32'(bus.mem_addr), 0);

        // CPU-only load
        tick();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        #2;
        chk("cpu_gnt0", 32'(bus.gnt0), 1);
        chk("cpu_rv1a", 32'(bus.rvalid1), 0);
        tick();
        bus.req0 = 1'b0;
        #2;
        chk("cpu_rv0",  32'(bus.rvalid0), 1);
        chk("cpu_rd",   32'(bus.rdata), 32'hBEEF);
        chk("cpu_rv1b", 32'(bus.rvalid1), 0);
        chk("cpu_gnt0_off", 32'(bus.gnt0), 0);

        // Loader stream of 10 writes, CPU idle
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.req1 = 1'b1; bus.we1 = 1'b1;
            bus.addr1 = 8'(8'h40 + i); bus.wdata1 = 16'(16'hA000 + i);
            #2;
            chk($sformatf("ld_gnt1_%0d", i), 32'(bus.gnt1), 1);
            chk($sformatf("ld_we_%0d", i),   32'(bus.mem_we), 1);
            chk($sformatf("ld_wd_%0d", i),   32'(bus.mem_wdata), 32'hA000 + i);
        end
        tick();
        bus.we1 = 1'b0; bus.addr1 = 8'h45;
        #2;
        chk("ld_rd_gnt", 32'(bus.gnt1), 1);
        chk("ld_rd_we",  32'(bus.mem_we), 0);
        tick();
        bus.req1 = 1'b0;
        #2;
        chk("ld_rv1", 32'(bus.rvalid1), 1);
        chk("ld_rdata", 32'(bus.rdata), 32'hA005);

        // Loader withdraws before grant; CPU keeps bursting, cnt saturates
        tick();
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'h10;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'h20;
        #2;
        chk("wd_tie_gnt0", 32'(bus.gnt0), 1);
        chk("wd_tie_gnt1", 32'(bus.gnt1), 0);
        tick();
        bus.req1 = 1'b0;
        for (int j = 0; j < 6; j++) begin
            if (j != 0) tick();
            #2;
            chk($sformatf("wd_gnt0_%0d", j), 32'(bus.gnt0), 1);
            chk($sformatf("wd_gnt1_%0d", j), 32'(bus.gnt1), 0);
            chk($sformatf("wd_addr_%0d", j), 32'(bus.mem_addr), 32'h10);
        end
        tick();
        bus.req1 = 1'b1;
        #2;
        chk("sat_gnt1", 32'(bus.gnt1), 1);
        chk("sat_gnt0", 32'(bus.gnt0), 0);
        tick();
        bus.req0 = 1'b0; bus.req1 = 1'b0;

        // Read then reset: the read's rvalid must be dropped
        tick();
        bus.req0 = 1'b1; bus.addr0 = 8'h10;
        #2;
        chk("rr_gnt0", 32'(bus.gnt0), 1);
        tick();
        bus.req0 = 1'b0; rst = 1'b1;
        #2;
        chk("rr_rv0_n1", 32'(bus.rvalid0), 0);
        tick();
        rst = 1'b0; bus.req0 = 1'b1; bus.req1 = 1'b1;
        #2;
        chk("rr_rv0_n2", 32'(bus.rvalid0), 0);
        chk("rr_tie_gnt0", 32'(bus.gnt0), 1);
        chk("rr_tie_gnt1", 32'(bus.gnt1), 0);
        tick();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
